mvm_stream_engine: RTL and testbench

//  Streaming signed fixed-point matrix-vector multiplier: y[j] = sum_i W[j][i]*x[i].

---
 rtl/mvm_stream_engine.sv | 190 +++++++++++++++++++
 tb/tb_mvm_stream_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_stream_engine.sv
// Streaming signed fixed-point matrix-vector multiplier (y = W*x) with LANES parallel MACs and saturation.
// Optional fused ReLU on the outputs when MVM_RELU_EN is defined.
module mvm_stream_engine #(
  parameter int IN_LEN     = 1152,
  parameter int OUT_LEN    = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 44
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   w_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(OUT_LEN)-1:0]    out_index,
  output logic                          busy,
  output logic                          done
);
  localparam int DW     = DATA_WIDTH;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int GROUPS = OUT_LEN / LANES;
  localparam int CNT_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              beats_done_q, beats_done_d;
  logic              p1_vld_q, p1_vld_d;
  logic              p1_last_q, p1_last_d;
  logic              acc_last_q, acc_last_d;
  logic signed [PW-1:0]        prod_q [LANES];
  logic signed [PW-1:0]        prod_d [LANES];
  logic signed [ACC_WIDTH-1:0] acc_q  [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d  [LANES];
  logic signed [DW-1:0]        x_mem  [IN_LEN];

  logic in_fire, w_fire, out_fire, idx_last, clr_acc;
  logic signed [PW-1:0]        x_ext, w_ext;
  logic signed [ACC_WIDTH-1:0] acc_sel, shifted;
  logic [ACC_WIDTH-DW:0]       top_bits;
  logic [DW-1:0]               y_sat;

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    w_ready   = (state_q == S_COMPUTE) && !beats_done_q;
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    in_fire   = in_valid && in_ready;
    w_fire    = w_valid && w_ready;
    out_fire  = out_valid && out_ready;
    idx_last  = (idx_q == CNT_W'(IN_LEN - 1));

    state_d      = state_q;
    idx_d        = idx_q;
    grp_d        = grp_q;
    lane_d       = lane_q;
    beats_done_d = beats_done_q;
    clr_acc      = 1'b0;
    // Two-stage MAC: stage 1 registers the product, stage 2 accumulates it.
    p1_vld_d   = w_fire;
    p1_last_d  = w_fire && idx_last;
    acc_last_d = p1_vld_q && p1_last_q;
    x_ext      = {{DW{x_mem[idx_q][DW-1]}}, x_mem[idx_q]};
    for (int k = 0; k < LANES; k++) begin
      w_ext     = {{DW{w_data[k*DW+DW-1]}}, w_data[k*DW +: DW]};
      prod_d[k] = w_fire ? (x_ext * w_ext) : prod_q[k];
      acc_d[k]  = p1_vld_q ? (acc_q[k] + {{(ACC_WIDTH-PW){prod_q[k][PW-1]}}, prod_q[k]})
                           : acc_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          idx_d = idx_last ? '0 : idx_q + 1'b1;
          if (idx_last) begin
            state_d      = S_COMPUTE;
            grp_d        = '0;
            beats_done_d = 1'b0;
            clr_acc      = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (w_fire) begin
          idx_d = idx_last ? '0 : idx_q + 1'b1;
          if (idx_last) beats_done_d = 1'b1;
        end
        if (acc_last_q) begin
          state_d = S_DRAIN;
          lane_d  = '0;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (lane_q == LANE_W'(LANES - 1)) begin
            lane_d = '0;
            if (grp_q == GRP_W'(GROUPS - 1)) begin
              state_d = S_DONE;
            end else begin
              grp_d        = grp_q + 1'b1;
              state_d      = S_COMPUTE;
              beats_done_d = 1'b0;
              clr_acc      = 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (clr_acc) begin
      for (int k = 0; k < LANES; k++) acc_d[k] = '0;
    end

    // Floor shift, then clamp when the bits above the output sign disagree with it.
    acc_sel  = acc_q[lane_q];
    shifted  = acc_sel >>> FRAC_BITS;
    top_bits = shifted[ACC_WIDTH-1:DW-1];
    if (!shifted[ACC_WIDTH-1] && (|top_bits)) y_sat = {1'b0, {(DW-1){1'b1}}};
    else if (shifted[ACC_WIDTH-1] && !(&top_bits)) y_sat = {1'b1, {(DW-1){1'b0}}};
    else y_sat = shifted[DW-1:0];
`ifdef MVM_RELU_EN
    out_data = y_sat[DW-1] ? '0 : y_sat;
`else
    out_data = y_sat;
`endif
    out_index = $bits(out_index)'(int'(grp_q) * LANES + int'(lane_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      grp_q        <= '0;
      lane_q       <= '0;
      beats_done_q <= 1'b0;
      p1_vld_q     <= 1'b0;
      p1_last_q    <= 1'b0;
      acc_last_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      grp_q        <= grp_d;
      lane_q       <= lane_d;
      beats_done_q <= beats_done_d;
      p1_vld_q     <= p1_vld_d;
      p1_last_q    <= p1_last_d;
      acc_last_q   <= acc_last_d;
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= prod_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) x_mem[idx_q] <= in_data;
  end
endmodule

// File: tb/tb_mvm_stream_engine.sv
// Directed bench for mvm_stream_engine at IN_LEN=8, OUT_LEN=4, LANES=2, Q8.8.
// Expected results come from a behavioural model and flow through a scoreboard queue.
module tb_mvm_stream_engine;
  localparam int IN_LEN = 8;
  localparam int OUT_LEN = 4;
  localparam int LANES = 2;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, in_valid, w_valid, out_ready;
  logic in_ready, w_ready, out_valid, busy, done;
  logic [DW-1:0] in_data, out_data;
  logic [LANES*DW-1:0] w_data;
  logic [1:0] out_index;

  mvm_stream_engine #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_WIDTH(DW), .FRAC_BITS(8),
    .LANES(LANES), .ACC_WIDTH(44)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [1:0] exp_idx_q[$];
  logic [DW-1:0] x_arr[IN_LEN];
  logic [DW-1:0] w_arr[OUT_LEN][IN_LEN];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_y(input int j);
    longint acc, sh;
    logic [DW-1:0] y;
    acc = 0;
    for (int i = 0; i < IN_LEN; i++)
      acc += longint'($signed(x_arr[i])) * longint'($signed(w_arr[j][i]));
    sh = acc >>> 8;
    if (sh > 32767) y = 16'h7FFF;
    else if (sh < -32768) y = 16'h8000;
    else y = sh[15:0];
`ifdef MVM_RELU_EN
    if (y[15]) y = 16'h0000;
`endif
    return y;
  endfunction

  task automatic set_test1;
    for (int i = 0; i < IN_LEN; i++) begin
      x_arr[i] = 16'h0100;
      for (int j = 0; j < OUT_LEN; j++) w_arr[j][i] = ((i % 4) == j) ? 16'h0100 : 16'h0000;
    end
  endtask

  task automatic set_const(input logic [DW-1:0] xv, input logic [DW-1:0] wv);
    for (int i = 0; i < IN_LEN; i++) begin
      x_arr[i] = xv;
      for (int j = 0; j < OUT_LEN; j++) w_arr[j][i] = wv;
    end
  endtask

  task automatic set_random;
    for (int i = 0; i < IN_LEN; i++) begin
      x_arr[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int j = 0; j < OUT_LEN; j++) w_arr[j][i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    end
  endtask

  task automatic send_x(input logic [DW-1:0] v, input logic pulse_start);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = v;
    start = pulse_start;
    while (!in_ready && n < 50) begin tick; n++; end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_w(input int g, input int i, input int gap);
    int n;
    n = 0;
    w_valid = 1'b0;
    repeat (gap) tick;
    w_valid = 1'b1;
    w_data = {w_arr[g*LANES+1][i], w_arr[g*LANES][i]};
    while (!w_ready && n < 50) begin tick; n++; end
    if (!w_ready) check("w_ready_wait", 32'(w_ready), 32'd1);
    tick;
    w_valid = 1'b0;
  endtask

  task automatic recv(input int stall);
    int n;
    logic [DW-1:0] e;
    logic [1:0] ei;
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    if (!out_valid) check("out_valid_wait", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      ei = exp_idx_q.pop_front();
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(e));
        check("stall_index", 32'(out_index), 32'(ei));
      end
      check("out_data", 32'(out_data), 32'(e));
      check("out_index", 32'(out_index), 32'(ei));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic run_job(input int max_gap, input int stall, input bit lat_chk, input bit restart_mid);
    int d0;
    d0 = done_cnt;
    for (int j = 0; j < OUT_LEN; j++) begin
      exp_q.push_back(model_y(j));
      exp_idx_q.push_back(2'(j));
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < IN_LEN; i++) send_x(x_arr[i], restart_mid && (i == 3));
    for (int g = 0; g < OUT_LEN / LANES; g++) begin
      for (int i = 0; i < IN_LEN; i++)
        send_w(g, i, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      if (lat_chk) begin
        check("lat_edge0", 32'(out_valid), 32'd0);
        tick;
        check("lat_edge1", 32'(out_valid), 32'd0);
        tick;
        check("lat_edge2", 32'(out_valid), 32'd1);
      end
      for (int k = 0; k < LANES; k++) recv((g == 0 && k == 0) ? stall : 0);
    end
    check("done_pulse", 32'(done), 32'd1);
    tick;
    check("done_low", 32'(done), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_w_ready"}, 32'(w_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_index"}, 32'(out_index), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; w_data = '0;
    tick; tick;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick;

    // 1: diagonal-style weights, latency check
    set_test1();
    run_job(0, 0, 1'b1, 1'b0);

    // 2: positive and negative saturation
    set_const(16'h7FFF, 16'h7FFF);
    run_job(0, 0, 1'b0, 1'b0);
    set_const(16'h7FFF, 16'h8000);
    run_job(0, 0, 1'b0, 1'b0);

    // 3: negative result (zeroed with ReLU)
    set_const(16'h0100, 16'hFF00);
    run_job(0, 0, 1'b0, 1'b0);

    // 4: back-pressure during drain, random data
    set_random();
    run_job(0, 10, 1'b0, 1'b0);

    // 5: reset in the middle of COMPUTE
    set_test1();
    d0 = done_cnt;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < IN_LEN; i++) send_x(x_arr[i], 1'b0);
    for (int i = 0; i < 3; i++) send_w(0, i, 0);
    reset = 1'b1;
    tick;
    check_idle_outputs("midreset");
    reset = 1'b0;
    tick;
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(0, 0, 1'b0, 1'b0);

    // 6: stray start during LOAD plus random weight gaps
    set_test1();
    run_job(3, 0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
